// File: rtl/cpu_pkg.sv
// Shared loader definitions: frame byte width and FSM state encoding.
package cpu_pkg;

  localparam int unsigned BYTE_WIDTH = 8;
  localparam int unsigned STATE_WIDTH = 3;

  localparam logic [STATE_WIDTH-1:0] S_IDLE    = 3'd0;
  localparam logic [STATE_WIDTH-1:0] S_LEN_HI  = 3'd1;
  localparam logic [STATE_WIDTH-1:0] S_LEN_LO  = 3'd2;
  localparam logic [STATE_WIDTH-1:0] S_DATA_HI = 3'd3;
  localparam logic [STATE_WIDTH-1:0] S_DATA_LO = 3'd4;
  localparam logic [STATE_WIDTH-1:0] S_CHECK   = 3'd5;
  localparam logic [STATE_WIDTH-1:0] S_DONE    = 3'd6;
  localparam logic [STATE_WIDTH-1:0] S_ERR     = 3'd7;

  typedef enum logic [STATE_WIDTH-1:0] {
    LD_IDLE    = S_IDLE,
    LD_LEN_HI  = S_LEN_HI,
    LD_LEN_LO  = S_LEN_LO,
    LD_DATA_HI = S_DATA_HI,
    LD_DATA_LO = S_DATA_LO,
    LD_CHECK   = S_CHECK,
    LD_DONE    = S_DONE,
    LD_ERR     = S_ERR
  } ld_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Loader bus bundle: inbound byte stream (valid/ready) and outbound
// instruction-memory write port.
//   byte_valid/byte_data : stream source -> loader
//   byte_ready           : loader -> stream source
//   imem_we/waddr/wdata  : loader -> instruction memory
// slave = loader side, master = stream source / memory side.
interface imem_loader_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8
);
  import cpu_pkg::*;

  logic                  byte_valid;
  logic [BYTE_WIDTH-1:0] byte_data;
  logic                  byte_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_waddr;
  logic [DATA_WIDTH-1:0] imem_wdata;

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_waddr, imem_wdata
  );

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_waddr, imem_wdata
  );

endinterface

// File: rtl/loader_chksum.sv
// Running XOR over accepted frame bytes.
//   clk, reset : clock, synchronous active-high reset
//   clear      : zero the sum (new frame)
//   en         : fold din into the sum this cycle
//   din        : byte to fold
//   sum        : current XOR of folded bytes
module loader_chksum
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  en,
  input  logic [BYTE_WIDTH-1:0] din,
  output logic [BYTE_WIDTH-1:0] sum
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum ^ din;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader. Receives LEN_HI, LEN_LO, N big-endian
// words and a trailing XOR checksum byte; writes words from address 0 and
// holds the CPU until a frame checks out.
//   clk, reset    : clock, synchronous active-high reset
//   start         : begin a load (honoured in IDLE, DONE, ERR)
//   bus (slave)   : byte stream in, instruction-memory write port out
//   cpu_hold      : keep CPU in reset
//   busy          : frame in progress
//   done, error   : sticky result of the last frame
//   words_written : words written in the current/last frame
module imem_loader
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned IMEM_DEPTH = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  imem_loader_if.slave        bus,
  output logic                cpu_hold,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [ADDR_WIDTH:0] words_written
);

  localparam int unsigned LEN_WIDTH = 2 * BYTE_WIDTH;
  localparam int unsigned WC_WIDTH  = ADDR_WIDTH + 1;

  ld_state_e             state;
  logic [BYTE_WIDTH-1:0] len_hi;
  logic [LEN_WIDTH-1:0]  len;
  logic [BYTE_WIDTH-1:0] hi_byte;
  logic                  imem_we_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BYTE_WIDTH-1:0] xor_sum;
  logic                  ready_c;
  logic                  accept_c;
  logic                  start_ok_c;
  logic [LEN_WIDTH-1:0]  len_c;

  // Ready depends on state only, never on byte_valid.
  always_comb begin
    ready_c = 1'b0;
    case (state)
      LD_LEN_HI, LD_LEN_LO, LD_DATA_HI, LD_DATA_LO, LD_CHECK: ready_c = 1'b1;
      default:                                                ready_c = 1'b0;
    endcase
  end

  assign accept_c   = bus.byte_valid && ready_c;
  assign start_ok_c = start && (state == LD_IDLE || state == LD_DONE || state == LD_ERR);
  assign len_c      = {len_hi, bus.byte_data};

  // Every frame byte except the checksum itself enters the running XOR.
  loader_chksum u_chksum (
    .clk   (clk),
    .reset (reset),
    .clear (start_ok_c),
    .en    (accept_c && (state != LD_CHECK)),
    .din   (bus.byte_data),
    .sum   (xor_sum)
  );

  // Frame FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= LD_IDLE;
      len_hi        <= '0;
      len           <= '0;
      hi_byte       <= '0;
      imem_we_q     <= 1'b0;
      waddr_q       <= '0;
      wdata_q       <= '0;
      cpu_hold      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      words_written <= '0;
    end else begin
      imem_we_q <= 1'b0;
      // Count a word once its write cycle has been presented.
      if (imem_we_q) begin
        words_written <= words_written + WC_WIDTH'(1);
      end

      case (state)
        LD_IDLE, LD_DONE, LD_ERR: begin
          if (start) begin
            state         <= LD_LEN_HI;
            len_hi        <= '0;
            len           <= '0;
            cpu_hold      <= 1'b1;
            busy          <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
            words_written <= '0;
          end
        end
        LD_LEN_HI: begin
          if (accept_c) begin
            len_hi <= bus.byte_data;
            state  <= LD_LEN_LO;
          end
        end
        LD_LEN_LO: begin
          if (accept_c) begin
            len <= len_c;
            if (len_c > LEN_WIDTH'(IMEM_DEPTH)) begin
              state <= LD_ERR;
              busy  <= 1'b0;
              error <= 1'b1;
            end else if (len_c == '0) begin
              state <= LD_CHECK;
            end else begin
              state <= LD_DATA_HI;
            end
          end
        end
        LD_DATA_HI: begin
          if (accept_c) begin
            hi_byte <= bus.byte_data;
            state   <= LD_DATA_LO;
          end
        end
        LD_DATA_LO: begin
          if (accept_c) begin
            imem_we_q <= 1'b1;
            wdata_q   <= DATA_WIDTH'({hi_byte, bus.byte_data});
            waddr_q   <= ADDR_WIDTH'(words_written);
            // words_written is already up to date: two accepts separate writes.
            if (LEN_WIDTH'(words_written) + LEN_WIDTH'(1) == len) begin
              state <= LD_CHECK;
            end else begin
              state <= LD_DATA_HI;
            end
          end
        end
        LD_CHECK: begin
          if (accept_c) begin
            busy <= 1'b0;
            if (bus.byte_data == xor_sum) begin
              state    <= LD_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= LD_ERR;
              error <= 1'b1;
            end
          end
        end
        default: state <= LD_IDLE;
      endcase
    end
  end

  assign bus.byte_ready = ready_c;
  // Kill a pending write in the same cycle reset is raised.
  assign bus.imem_we    = imem_we_q & ~reset;
  assign bus.imem_waddr = waddr_q;
  assign bus.imem_wdata = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed loads, checksum pass/fail, length
// overflow, empty frame, bursty stream with stray start, mid-frame reset.
module tb_imem_loader;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic       error;
  logic [8:0] words_written;

  imem_loader_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus ();

  imem_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .IMEM_DEPTH(256)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .bus           (bus),
    .cpu_hold      (cpu_hold),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write monitor: records every strobe seen at the falling edge.
  int         wr_cnt  = 0;
  int         b2b_cnt = 0;
  logic       prev_we = 1'b0;
  logic [7:0] wr_addr [0:1023];
  logic [15:0] wr_data [0:1023];

  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      if (wr_cnt < 1024) begin
        wr_addr[wr_cnt] = bus.imem_waddr;
        wr_data[wr_cnt] = bus.imem_wdata;
      end
      wr_cnt++;
      if (prev_we) b2b_cnt++;
    end
    prev_we = (bus.imem_we === 1'b1);
  end

  logic [7:0] fq [$];

  // Entered and left at a falling edge.
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (bus.byte_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (bus.byte_ready !== 1'b1) begin
      check("ready_timeout", 32'(bus.byte_ready), 32'd1);
      bus.byte_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  // Idle cycles; each also probes that byte_ready ignores byte_valid.
  task automatic gap(input int n);
    logic r0, r1;
    for (int i = 0; i < n; i++) begin
      r0 = bus.byte_ready;
      bus.byte_valid = 1'b1;
      #1 r1 = bus.byte_ready;
      bus.byte_valid = 1'b0;
      check("ready_vs_valid", 32'(r1), 32'(r0));
      @(negedge clk);
    end
  endtask

  task automatic send_range(input int first, input int last, input int max_gap);
    for (int i = first; i <= last; i++) begin
      send_byte(fq[i]);
      if (max_gap > 0) gap(int'($urandom_range(0, max_gap)));
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_write(input string tag, input int idx, input logic [7:0] a, input logic [15:0] d);
    check({tag, "_addr"}, 32'(wr_addr[idx]), 32'(a));
    check({tag, "_data"}, 32'(wr_data[idx]), 32'(d));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
    check({tag, "_we"},    32'(bus.imem_we),    32'd0);
    check({tag, "_waddr"}, 32'(bus.imem_waddr), 32'd0);
    check({tag, "_wdata"}, 32'(bus.imem_wdata), 32'd0);
    check({tag, "_hold"},  32'(cpu_hold),       32'd0);
    check({tag, "_busy"},  32'(busy),           32'd0);
    check({tag, "_done"},  32'(done),           32'd0);
    check({tag, "_error"}, 32'(error),          32'd0);
    check({tag, "_wcnt"},  32'(words_written),  32'd0);
  endtask

  int base;

  initial begin
    reset          = 1'b1;
    start          = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Good 2-word frame: checksum 00^02^12^34^AB^CD = 0x42.
    base = wr_cnt;
    do_start();
    check("t1_hold_on", 32'(cpu_hold), 32'd1);
    check("t1_busy_on", 32'(busy), 32'd1);
    check("t1_ready", 32'(bus.byte_ready), 32'd1);
    fq = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    send_range(0, 6, 0);
    check("t1_nwr", 32'(wr_cnt - base), 32'd2);
    check_write("t1_w0", base, 8'd0, 16'h1234);
    check_write("t1_w1", base + 1, 8'd1, 16'hABCD);
    check("t1_done", 32'(done), 32'd1);
    check("t1_error", 32'(error), 32'd0);
    check("t1_hold", 32'(cpu_hold), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_wcnt", 32'(words_written), 32'd2);

    // Same frame, wrong checksum: writes still land, then ERR.
    base = wr_cnt;
    do_start();
    check("t2_done_clr", 32'(done), 32'd0);
    fq = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    send_range(0, 6, 0);
    check("t2_nwr", 32'(wr_cnt - base), 32'd2);
    check_write("t2_w0", base, 8'd0, 16'h1234);
    check_write("t2_w1", base + 1, 8'd1, 16'hABCD);
    check("t2_error", 32'(error), 32'd1);
    check("t2_done", 32'(done), 32'd0);
    check("t2_hold", 32'(cpu_hold), 32'd1);
    check("t2_wcnt", 32'(words_written), 32'd2);

    // Oversize length 257: ERR right after LEN_LO, stream then ignored.
    base = wr_cnt;
    do_start();
    check("t3_err_clr", 32'(error), 32'd0);
    fq = '{8'h01, 8'h01};
    send_range(0, 1, 0);
    check("t3_error", 32'(error), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_ready", 32'(bus.byte_ready), 32'd0);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h55;
    repeat (3) @(negedge clk);
    check("t3_ready_hold", 32'(bus.byte_ready), 32'd0);
    bus.byte_valid = 1'b0;
    check("t3_nwr", 32'(wr_cnt - base), 32'd0);
    check("t3_hold", 32'(cpu_hold), 32'd1);

    // Empty frame, then a 1-word frame: chk 00^01^BE^EF = 0x50.
    base = wr_cnt;
    do_start();
    fq = '{8'h00, 8'h00, 8'h00};
    send_range(0, 2, 0);
    check("t4_done", 32'(done), 32'd1);
    check("t4_nwr", 32'(wr_cnt - base), 32'd0);
    check("t4_wcnt", 32'(words_written), 32'd0);
    check("t4_hold", 32'(cpu_hold), 32'd0);
    do_start();
    fq = '{8'h00, 8'h01, 8'hBE, 8'hEF, 8'h50};
    send_range(0, 4, 0);
    check("t4b_nwr", 32'(wr_cnt - base), 32'd1);
    check_write("t4b_w0", base, 8'd0, 16'hBEEF);
    check("t4b_wcnt", 32'(words_written), 32'd1);
    check("t4b_done", 32'(done), 32'd1);

    // Bursty 3-word frame with a stray start: chk 00^03^11^22^33^44^55^66 = 0x74.
    base = wr_cnt;
    do_start();
    fq = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h74};
    send_range(0, 3, 3);
    do_start();
    check("t5_busy_mid", 32'(busy), 32'd1);
    send_range(4, 8, 3);
    check("t5_nwr", 32'(wr_cnt - base), 32'd3);
    check_write("t5_w0", base, 8'd0, 16'h1122);
    check_write("t5_w1", base + 1, 8'd1, 16'h3344);
    check_write("t5_w2", base + 2, 8'd2, 16'h5566);
    check("t5_done", 32'(done), 32'd1);
    check("t5_error", 32'(error), 32'd0);
    check("t5_wcnt", 32'(words_written), 32'd3);

    // Reset during the write cycle of word index 3.
    do_start();
    fq = '{8'h00, 8'h05, 8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h03, 8'h04, 8'h04};
    send_range(0, 9, 0);
    #1;
    check("t6_pre_we", 32'(bus.imem_we), 32'd1);
    check("t6_pre_addr", 32'(bus.imem_waddr), 32'd3);
    check("t6_pre_data", 32'(bus.imem_wdata), 32'h0404);
    reset = 1'b1;
    #1;
    check("t6_we_kill", 32'(bus.imem_we), 32'd0);
    @(negedge clk);
    check_reset_outputs("t6_rst");
    reset = 1'b0;
    @(negedge clk);
    check("t6_idle_ready", 32'(bus.byte_ready), 32'd0);
    check("t6_idle_busy", 32'(busy), 32'd0);

    check("we_back_to_back", 32'(b2b_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
